chip8_mem_arbiter: RTL and testbench

- Shares the single-port CHIP-8 `memory` block (4096 x 8) between three requesters: P0 = CPU fetch/execute, P1 = display/sprite engine, P2 = program loader.
- Sits between the requesters and `memory`. It owns `memory`'s read, read_addr, write, write_addr and write_data inputs, and consumes read_data and read_ack.
- Round-robin arbitration, one transaction in flight at a time, with a read watchdog.

---
 rtl/chip8_mem_arbiter_if.sv | 37 +++
 rtl/chip8_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_arbiter_if.sv
// Requester and memory-side signals of the CHIP-8 memory arbiter.
// slave = arbiter view, master = requesters plus the memory block.
interface chip8_mem_arbiter_if;
  logic        p0_req, p1_req, p2_req;
  logic        p0_we, p1_we, p2_we;
  logic [11:0] p0_addr, p1_addr, p2_addr;
  logic [7:0]  p0_wdata, p1_wdata, p2_wdata;
  logic        p0_ack, p1_ack, p2_ack;
  logic [7:0]  p0_rdata, p1_rdata, p2_rdata;
  logic        p0_err, p1_err, p2_err;
  logic        wr_blocked;
  logic        mem_read;
  logic [11:0] mem_read_addr;
  logic [7:0]  mem_read_data;
  logic        mem_read_ack;
  logic        mem_write;
  logic [11:0] mem_write_addr;
  logic [7:0]  mem_write_data;

  modport slave (
    input  p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
           p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
           mem_read_data, mem_read_ack,
    output p0_ack, p1_ack, p2_ack, p0_rdata, p1_rdata, p2_rdata,
           p0_err, p1_err, p2_err, wr_blocked,
           mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data
  );

  modport master (
    output p0_req, p1_req, p2_req, p0_we, p1_we, p2_we,
           p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
           mem_read_data, mem_read_ack,
    input  p0_ack, p1_ack, p2_ack, p0_rdata, p1_rdata, p2_rdata,
           p0_err, p1_err, p2_err, wr_blocked,
           mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Round-robin arbiter sharing the CHIP-8 memory between CPU, display and loader.
// Define MEM_ARB_ROM_PROTECT_EN to drop writes below PROTECT_TOP.
module chip8_mem_arbiter #(
  parameter int          TIMEOUT     = 15,
  parameter logic [11:0] PROTECT_TOP = 12'h200
) (
  input  logic clk,
  input  logic rst_n,
  chip8_mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
`ifdef MEM_ARB_ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  state_t      state, state_d;
  logic [1:0]  owner, owner_d, rr_last, rr_last_d;
  logic [7:0]  wdog, wdog_d;
  logic [2:0]  ack, ack_d, err, err_d;
  logic [7:0]  rdata [3];
  logic [7:0]  rdata_d [3];
  logic        blocked, blocked_d;
  logic        mem_read, mem_read_d, mem_write, mem_write_d;
  logic [11:0] read_addr, read_addr_d, write_addr, write_addr_d;
  logic [7:0]  write_data, write_data_d;

  logic [2:0]  req, we;
  logic [11:0] addr [3];
  logic [7:0]  wdata [3];
  logic [1:0]  order [3];
  logic        found, protect_hit;
  logic [1:0]  grant;

  assign req      = {bus.p2_req, bus.p1_req, bus.p0_req};
  assign we       = {bus.p2_we, bus.p1_we, bus.p0_we};
  assign addr[0]  = bus.p0_addr;
  assign addr[1]  = bus.p1_addr;
  assign addr[2]  = bus.p2_addr;
  assign wdata[0] = bus.p0_wdata;
  assign wdata[1] = bus.p1_wdata;
  assign wdata[2] = bus.p2_wdata;

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    rr_last_d    = rr_last;
    wdog_d       = '0;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = rdata;
    blocked_d    = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    read_addr_d  = read_addr;
    write_addr_d = write_addr;
    write_data_d = write_data;
    found        = 1'b0;
    grant        = 2'd0;
    protect_hit  = 1'b0;

    // Search starts just after the last winner and wraps around.
    case (rr_last)
      2'd0:    order = '{2'd1, 2'd2, 2'd0};
      2'd1:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase

    case (state)
      IDLE: begin
        for (int k = 0; k < 3; k++) begin
          if (!found && req[order[k]]) begin
            found = 1'b1;
            grant = order[k];
          end
        end
        protect_hit = ROM_PROTECT && (addr[grant] < PROTECT_TOP);
        if (found) begin
          owner_d   = grant;
          rr_last_d = grant;
          if (we[grant] && protect_hit) begin
            state_d        = DONE;
            ack_d[grant]   = 1'b1;
            blocked_d      = 1'b1;
          end else if (we[grant]) begin
            state_d      = WR_ISSUE;
            mem_write_d  = 1'b1;
            write_addr_d = addr[grant];
            write_data_d = wdata[grant];
          end else begin
            state_d     = RD_ISSUE;
            mem_read_d  = 1'b1;
            read_addr_d = addr[grant];
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        // A real ack wins over a timeout landing in the same cycle.
        if (bus.mem_read_ack) begin
          state_d        = DONE;
          ack_d[owner]   = 1'b1;
          rdata_d[owner] = bus.mem_read_data;
        end else if ((wdog + 8'd1) >= TIMEOUT_CNT) begin
          state_d        = DONE;
          ack_d[owner]   = 1'b1;
          err_d[owner]   = 1'b1;
          rdata_d[owner] = 8'hFF;
        end else begin
          wdog_d = wdog + 8'd1;
        end
      end
      WR_ISSUE: begin
        state_d      = DONE;
        ack_d[owner] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      rr_last    <= 2'd2;
      wdog       <= '0;
      ack        <= '0;
      err        <= '0;
      rdata      <= '{default: 8'h00};
      blocked    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      read_addr  <= '0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      rr_last    <= rr_last_d;
      wdog       <= wdog_d;
      ack        <= ack_d;
      err        <= err_d;
      rdata      <= rdata_d;
      blocked    <= blocked_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      read_addr  <= read_addr_d;
      write_addr <= write_addr_d;
      write_data <= write_data_d;
    end
  end

  assign bus.p0_ack         = ack[0];
  assign bus.p1_ack         = ack[1];
  assign bus.p2_ack         = ack[2];
  assign bus.p0_err         = err[0];
  assign bus.p1_err         = err[1];
  assign bus.p2_err         = err[2];
  assign bus.p0_rdata       = rdata[0];
  assign bus.p1_rdata       = rdata[1];
  assign bus.p2_rdata       = rdata[2];
  assign bus.wr_blocked     = blocked;
  assign bus.mem_read       = mem_read;
  assign bus.mem_read_addr  = read_addr;
  assign bus.mem_write      = mem_write;
  assign bus.mem_write_addr = write_addr;
  assign bus.mem_write_data = write_data;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter: directed scenarios, then random
// contention checked against a transaction-level model of the arbiter.
module tb_chip8_mem_arbiter;
  localparam int          TIMEOUT     = 15;
  localparam logic [11:0] PROTECT_TOP = 12'h200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip8_mem_arbiter_if bus();

  chip8_mem_arbiter #(.TIMEOUT(TIMEOUT), .PROTECT_TOP(PROTECT_TOP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural memory: one-cycle read latency, ack can be disabled to force timeouts.
  logic [7:0] mem [4096];
  bit         mem_ack_en = 1'b1;
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_write_addr] <= bus.mem_write_data;
    if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_read_addr];
    bus.mem_read_ack <= bus.mem_read && mem_ack_en;
  end

  int          tests = 0, fails = 0, cyc = 0;
  logic [7:0]  ref_mem [4096];
  logic [7:0]  exp_rdata [3];
  int          rr_last;
  bit          pend [3];
  bit          t_we [3];
  logic [11:0] t_addr [3];
  logic [7:0]  t_wdata [3];
  int          rd_pulses, wr_pulses;
  bit          overlap;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_read) rd_pulses++;
    if (bus.mem_write) wr_pulses++;
    if (bus.mem_read && bus.mem_write) overlap = 1'b1;
  endtask

  task automatic drivePorts();
    bus.p0_req = pend[0]; bus.p0_we = t_we[0]; bus.p0_addr = t_addr[0]; bus.p0_wdata = t_wdata[0];
    bus.p1_req = pend[1]; bus.p1_we = t_we[1]; bus.p1_addr = t_addr[1]; bus.p1_wdata = t_wdata[1];
    bus.p2_req = pend[2]; bus.p2_we = t_we[2]; bus.p2_addr = t_addr[2]; bus.p2_wdata = t_wdata[2];
  endtask

  task automatic applyStimulus(input int p, input bit we, input logic [11:0] a, input logic [7:0] d);
    pend[p] = 1'b1; t_we[p] = we; t_addr[p] = a; t_wdata[p] = d;
    drivePorts();
  endtask

  task automatic idleAll();
    for (int p = 0; p < 3; p++) pend[p] = 1'b0;
    drivePorts();
    tick();
  endtask

  function automatic int predictPort();
    for (int k = 1; k <= 3; k++) begin
      if (pend[(rr_last + k) % 3]) return (rr_last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] ackVec();
    return {bus.p2_ack, bus.p1_ack, bus.p0_ack};
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {23'd0, bus.p0_ack, bus.p1_ack, bus.p2_ack, bus.p0_err, bus.p1_err,
                 bus.p2_err, bus.wr_blocked, bus.mem_read, bus.mem_write}, 32'd0);
    checkOutput({tag, "_rdata"}, {8'd0, bus.p0_rdata, bus.p1_rdata, bus.p2_rdata}, 32'd0);
    checkOutput({tag, "_membus"}, {bus.mem_read_addr, bus.mem_write_addr, bus.mem_write_data}, 32'd0);
  endtask

  // Serve pending requests in predicted round-robin order; hold keeps winners requesting.
  task automatic runBatch(input int n_acks, input bit hold);
    int sample, p, lat, waited;
    bit got, blocked;
    sample = cyc;
    rd_pulses = 0; wr_pulses = 0; overlap = 1'b0;
    for (int i = 0; i < n_acks; i++) begin
      p = predictPort();
      if (p < 0) break;
      blocked = 1'b0;
`ifdef MEM_ARB_ROM_PROTECT_EN
      blocked = t_we[p] && (t_addr[p] < PROTECT_TOP);
`endif
      if (!t_we[p]) lat = mem_ack_en ? 3 : 2 + TIMEOUT;
      else          lat = blocked ? 1 : 2;
      got = 1'b0;
      waited = 0;
      while (!got && waited < 64) begin
        tick();
        waited++;
        if (ackVec() != 3'b000) got = 1'b1;
      end
      checkOutput("ack_seen", {31'd0, got}, 32'd1);
      if (!got) break;
      checkOutput("ack_port", {29'd0, ackVec()}, 32'(1 << p));
      checkOutput("ack_cycle", cyc - sample, lat);
      if (!t_we[p]) exp_rdata[p] = mem_ack_en ? ref_mem[t_addr[p]] : 8'hFF;
      else if (!blocked) ref_mem[t_addr[p]] = t_wdata[p];
      checkOutput("rdata_all", {8'd0, bus.p2_rdata, bus.p1_rdata, bus.p0_rdata},
                  {8'd0, exp_rdata[2], exp_rdata[1], exp_rdata[0]});
      checkOutput("err", {29'd0, bus.p2_err, bus.p1_err, bus.p0_err},
                  (!t_we[p] && !mem_ack_en) ? 32'(1 << p) : 32'd0);
      checkOutput("wr_blocked", {31'd0, bus.wr_blocked}, {31'd0, blocked});
      checkOutput("rd_pulses", rd_pulses, t_we[p] ? 0 : 1);
      checkOutput("wr_pulses", wr_pulses, (t_we[p] && !blocked) ? 1 : 0);
      checkOutput("rw_overlap", {31'd0, overlap}, 32'd0);
      rr_last = p;
      rd_pulses = 0; wr_pulses = 0;
      if (!hold) begin
        pend[p] = 1'b0;
        drivePorts();
      end
      sample = cyc + 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    for (int p = 0; p < 3; p++) begin
      pend[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = '0; t_wdata[p] = '0; exp_rdata[p] = 8'h00;
    end
    bus.mem_read_data = 8'h00;
    bus.mem_read_ack  = 1'b0;
    rr_last = 2;
    drivePorts();

    repeat (3) tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    applyStimulus(0, 1'b0, 12'h000, 8'h00);
    runBatch(1, 1'b0);
    idleAll();
    checkOutput("first_read_rdata", {24'd0, bus.p0_rdata}, 32'h00);

    applyStimulus(2, 1'b1, 12'h300, 8'hA5);
    runBatch(1, 1'b0);
    idleAll();
    applyStimulus(1, 1'b0, 12'h300, 8'h00);
    runBatch(1, 1'b0);
    idleAll();
    checkOutput("readback_300", {24'd0, bus.p1_rdata}, 32'hA5);

    applyStimulus(0, 1'b1, 12'h1FF, 8'h55);
    runBatch(1, 1'b0);
    idleAll();
    applyStimulus(0, 1'b0, 12'h1FF, 8'h00);
    runBatch(1, 1'b0);
    idleAll();
`ifdef MEM_ARB_ROM_PROTECT_EN
    checkOutput("rom_readback", {24'd0, bus.p0_rdata}, 32'h00);
`else
    checkOutput("rom_readback", {24'd0, bus.p0_rdata}, 32'h55);
`endif

    mem_ack_en = 1'b0;
    applyStimulus(1, 1'b0, 12'h300, 8'h00);
    runBatch(1, 1'b0);
    idleAll();
    checkOutput("timeout_rdata", {24'd0, bus.p1_rdata}, 32'hFF);
    mem_ack_en = 1'b1;
    applyStimulus(2, 1'b0, 12'h300, 8'h00);
    runBatch(1, 1'b0);
    idleAll();
    checkOutput("after_timeout", {24'd0, bus.p2_rdata}, 32'hA5);

    // Reset lands while the read sits in RD_WAIT.
    mem_ack_en = 1'b0;
    applyStimulus(2, 1'b0, 12'h123, 8'h00);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    for (int p = 0; p < 3; p++) pend[p] = 1'b0;
    drivePorts();
    tick();
    tick();
    checkOutput("reset_noack", {29'd0, ackVec()}, 32'd0);
    rst_n = 1'b1;
    mem_ack_en = 1'b1;
    rr_last = 2;
    for (int p = 0; p < 3; p++) exp_rdata[p] = 8'h00;
    tick();

    applyStimulus(0, 1'b0, 12'h300, 8'h00);
    applyStimulus(1, 1'b0, 12'h1FF, 8'h00);
    applyStimulus(2, 1'b0, 12'h000, 8'h00);
    runBatch(4, 1'b1);
    idleAll();
    checkOutput("rotation_last_p0", {24'd0, bus.p0_rdata}, 32'hA5);

    repeat (40) begin
      int mask;
      mask = $urandom_range(1, 7);
      mem_ack_en = ($urandom_range(0, 7) != 0);
      for (int p = 0; p < 3; p++) begin
        if (mask[p]) applyStimulus(p, 1'($urandom_range(0, 1)),
                                   12'(12'h1F0 + $urandom_range(0, 31)), 8'($urandom));
      end
      runBatch(3, 1'b0);
      idleAll();
    end
    mem_ack_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
